// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider (quotient/remainder); signed mode under SEQ_DIVIDER_SIGNED_EN
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] data1_in,
    input  logic [WIDTH-1:0] data2_in,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             div_zero_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;    // partial remainder
    logic [WIDTH-1:0] quo_r;    // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] div_r;    // divisor magnitude

    logic             div_by_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic             last_iter;

    assign div_by_zero = (data2_in == '0);
    assign last_iter   = (cnt == CNT_W'(1));

    // WIDTH+1-bit trial subtraction so the shifted-out MSB is never lost
    assign shifted  = {rem_r, quo_r[WIDTH-1]};
    assign trial    = shifted - {1'b0, div_r};
    assign trial_ok = (shifted >= {1'b0, div_r});

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_q;    // quotient must be negated in FIX
    logic neg_r;    // remainder must be negated in FIX

    assign a_neg = signed_i & data1_in[WIDTH-1];
    assign b_neg = signed_i & data2_in[WIDTH-1];
    assign mag_a = a_neg ? (~data1_in + WIDTH'(1)) : data1_in;
    assign mag_b = b_neg ? (~data2_in + WIDTH'(1)) : data2_in;
`else
    logic unused_signed;

    assign unused_signed = signed_i;
    assign mag_a         = data1_in;
    assign mag_b         = data2_in;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    // divide-by-zero skips CALC but still takes one busy cycle in FIX
                    state_nxt = div_by_zero ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                busy_o = 1'b1;
                if (last_iter) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy_o    = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, shift-and-subtract iterations and result write-back
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt        <= '0;
            rem_r      <= '0;
            quo_r      <= '0;
            div_r      <= '0;
            quot_o     <= '0;
            rem_o      <= '0;
            div_zero_o <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        div_zero_o <= div_by_zero;
                        div_r      <= mag_b;
                        if (div_by_zero) begin
                            // preload the fixed divide-by-zero result; FIX passes it through
                            cnt   <= '0;
                            rem_r <= data1_in;
                            quo_r <= '1;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
`endif
                        end else begin
                            cnt   <= CNT_W'(WIDTH);
                            rem_r <= '0;
                            quo_r <= mag_a;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
`endif
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (trial_ok) begin
                        rem_r <= trial[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= shifted[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    quot_o <= neg_q ? (~quo_r + WIDTH'(1)) : quo_r;
                    rem_o  <= neg_r ? (~rem_r + WIDTH'(1)) : rem_r;
`else
                    quot_o <= quo_r;
                    rem_o  <= rem_r;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
